// File: rtl/riscboy_ppu_ahbl_read_port.sv
// Halfword read port onto an AHB-Lite master: one transfer in address phase, one in data phase.
// Two-cycle latency at zero wait states; requests stall on hready, responses have no backpressure.
module riscboy_ppu_ahbl_read_port #(
  parameter int W_ADDR  = 18,
  parameter int W_DATA  = 16,
  parameter int W_HADDR = 32,
  parameter int W_HDATA = 32,
  parameter logic [W_HADDR-1:0] ADDR_BASE = 32'h2008_0000
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req_addr_vld,
  output logic               req_addr_rdy,
  input  logic [W_ADDR-1:0]  req_addr,

  output logic               rsp_data_vld,
  output logic [W_DATA-1:0]  rsp_data,
  output logic               rsp_err,

  output logic               err_sticky,
  input  logic               err_clr,

  output logic [W_HADDR-1:0] ahblm_haddr,
  output logic [1:0]         ahblm_htrans,
  output logic               ahblm_hwrite,
  output logic [2:0]         ahblm_hsize,
  output logic [2:0]         ahblm_hburst,
  output logic [3:0]         ahblm_hprot,
  output logic               ahblm_hmastlock,
  input  logic               ahblm_hready,
  input  logic               ahblm_hresp,
  input  logic [W_HDATA-1:0] ahblm_hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic              aphase_vld;
  logic [W_ADDR-1:0] aphase_addr;
  logic              dphase_vld;
  logic              dphase_lane;
  logic              accept;
  logic [15:0]       lane_data;

  assign req_addr_rdy = !aphase_vld || ahblm_hready;
  assign accept       = req_addr_vld && req_addr_rdy;

  // An empty address phase can be refilled even while the bus is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aphase_vld  <= 1'b0;
      aphase_addr <= '0;
    end else if (accept) begin
      aphase_vld  <= 1'b1;
      aphase_addr <= req_addr;
    end else if (ahblm_hready) begin
      aphase_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dphase_vld  <= 1'b0;
      dphase_lane <= 1'b0;
    end else if (ahblm_hready) begin
      dphase_vld  <= aphase_vld;
      dphase_lane <= aphase_addr[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (rsp_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

  assign ahblm_haddr     = ADDR_BASE | W_HADDR'({aphase_addr, 1'b0});
  // First cycle of an ERROR response: drop the pending transfer to IDLE, re-issue next cycle.
  assign ahblm_htrans    = (aphase_vld && !(ahblm_hresp && !ahblm_hready)) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahblm_hwrite    = 1'b0;
  assign ahblm_hsize     = 3'b001;
  assign ahblm_hburst    = 3'b000;
  assign ahblm_hprot     = 4'b0011;
  assign ahblm_hmastlock = 1'b0;

  generate
    if (W_HDATA == 32) begin : g_lane32
      assign lane_data = dphase_lane ? ahblm_hrdata[31:16] : ahblm_hrdata[15:0];
    end else begin : g_lane16
      assign lane_data = ahblm_hrdata[15:0];
    end
  endgenerate

  assign rsp_data_vld = dphase_vld && ahblm_hready;
  assign rsp_err      = rsp_data_vld && ahblm_hresp;
  assign rsp_data     = rsp_err ? '0 : W_DATA'(lane_data);

endmodule

// File: tb/tb_riscboy_ppu_ahbl_read_port.sv
// Bench for the PPU AHB-Lite read port: small AHB slave model plus an in-order response scoreboard.
module tb_riscboy_ppu_ahbl_read_port;

  logic        clk;
  logic        rst;
  logic        req_addr_vld;
  logic        req_addr_rdy;
  logic [17:0] req_addr;
  logic        rsp_data_vld;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        err_sticky;
  logic        err_clr;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_cnt  = 0;
  int base_cnt;

  logic        fixed_mode;
  logic        s_vld, n_vld;
  logic [31:0] s_addr, n_addr;
  logic [17:0] q[$];

  riscboy_ppu_ahbl_read_port dut (
    .clk             (clk),
    .rst             (rst),
    .req_addr_vld    (req_addr_vld),
    .req_addr_rdy    (req_addr_rdy),
    .req_addr        (req_addr),
    .rsp_data_vld    (rsp_data_vld),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .err_sticky      (err_sticky),
    .err_clr         (err_clr),
    .ahblm_haddr     (haddr),
    .ahblm_htrans    (htrans),
    .ahblm_hwrite    (hwrite),
    .ahblm_hsize     (hsize),
    .ahblm_hburst    (hburst),
    .ahblm_hprot     (hprot),
    .ahblm_hmastlock (hmastlock),
    .ahblm_hready    (hready),
    .ahblm_hresp     (hresp),
    .ahblm_hrdata    (hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic fx, input logic [31:0] ha);
    logic [15:0] w;
    w = ha[17:2];
    return fx ? 32'hBEEF_1234 : {w ^ 16'h3C3C, w + 16'h0101};
  endfunction

  function automatic logic [31:0] exp_haddr(input logic [17:0] a);
    return 32'h2008_0000 | {13'b0, a, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [17:0] a, input logic hr, input logic hs);
    @(posedge clk);
    #1;
    req_addr_vld = v;
    req_addr     = a;
    hready       = hr;
    hresp        = hs;
    @(negedge clk);
    #1;
  endtask

  assign hrdata = s_vld ? data_of(fixed_mode, s_addr) : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld  <= 1'b0;
      s_addr <= '0;
    end else begin
      s_vld  <= n_vld;
      s_addr <= n_addr;
    end
  end

  // Scoreboard and slave sampling, away from the active edge.
  always @(negedge clk) begin
    logic [17:0] a;
    logic [31:0] d;
    logic [15:0] e;
    if (rst) begin
      q.delete();
      n_vld  <= 1'b0;
      n_addr <= '0;
    end else begin
      if (req_addr_vld && req_addr_rdy) q.push_back(req_addr);
      if (rsp_data_vld) begin
        rsp_cnt++;
        check("rsp_outstanding", 32'(q.size() != 0), 1);
        check("slave_dphase", s_vld, 1);
        if (q.size() != 0) begin
          a = q.pop_front();
          d = data_of(fixed_mode, exp_haddr(a));
          e = hresp ? 16'h0 : (a[0] ? d[31:16] : d[15:0]);
          check("dph_addr", s_addr, exp_haddr(a));
          check("rsp_data", rsp_data, e);
          check("rsp_err", rsp_err, hresp);
        end
      end
      if (hready) begin
        n_vld  <= (htrans == 2'b10);
        n_addr <= haddr;
      end
    end
  end

  initial begin
    rst = 1'b0; req_addr_vld = 1'b0; req_addr = '0;
    hready = 1'b1; hresp = 1'b0; err_clr = 1'b0; fixed_mode = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_rsp_vld", rsp_data_vld, 0);
    check("rst_htrans", htrans, 2'b00);
    check("rst_rdy", req_addr_rdy, 1);
    check("rst_sticky", err_sticky, 0);
    check("const_ctrl", {hwrite, hsize, hburst, hprot, hmastlock}, {1'b0, 3'b001, 3'b000, 4'b0011, 1'b0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single even-lane read and latency
    step(1, 18'h00010, 1, 0);
    check("s_rdy", req_addr_rdy, 1);
    check("s_htrans_n", htrans, 2'b00);
    step(0, 18'h0, 1, 0);
    check("s_htrans_n1", htrans, 2'b10);
    check("s_haddr", haddr, 32'h2008_0020);
    check("s_rsp_n1", rsp_data_vld, 0);
    step(0, 18'h0, 1, 0);
    check("s_rsp_n2", rsp_data_vld, 1);
    check("s_data", rsp_data, 16'h1234);

    // Odd lane
    step(1, 18'h00011, 1, 0);
    step(0, 18'h0, 1, 0);
    check("o_haddr", haddr, 32'h2008_0022);
    step(0, 18'h0, 1, 0);
    check("o_rsp", rsp_data_vld, 1);
    check("o_data", rsp_data, 16'hBEEF);

    // Streaming eight back-to-back reads
    fixed_mode = 1'b0;
    base_cnt = rsp_cnt;
    for (int i = 0; i < 8; i++) begin
      step(1, 18'h00100 + 18'(i * 3), 1, 0);
      check("st_rdy", req_addr_rdy, 1);
      if (i > 0) begin
        check("st_htrans", htrans, 2'b10);
        check("st_haddr", haddr, exp_haddr(18'h00100 + 18'((i - 1) * 3)));
      end
    end
    step(0, 18'h0, 1, 0);
    check("st_htrans_last", htrans, 2'b10);
    check("st_haddr_last", haddr, exp_haddr(18'h00100 + 18'd21));
    step(0, 18'h0, 1, 0);
    check("st_idle", htrans, 2'b00);
    step(0, 18'h0, 1, 0);
    check("st_count", rsp_cnt - base_cnt, 8);

    // Wait states: data phase stalled for three cycles
    base_cnt = rsp_cnt;
    step(1, 18'h00200, 1, 0);
    step(1, 18'h00201, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 18'h0, 0, 0);
      check("ws_htrans", htrans, 2'b10);
      check("ws_haddr", haddr, exp_haddr(18'h00201));
      check("ws_rdy", req_addr_rdy, 0);
      check("ws_rsp", rsp_data_vld, 0);
    end
    step(0, 18'h0, 1, 0);
    check("ws_rsp_a", rsp_data_vld, 1);
    step(0, 18'h0, 1, 0);
    check("ws_rsp_b", rsp_data_vld, 1);
    step(0, 18'h0, 1, 0);
    check("ws_count", rsp_cnt - base_cnt, 2);

    // Two-cycle ERROR response with a pending address phase
    step(1, 18'h00300, 1, 0);
    step(1, 18'h00301, 1, 0);
    step(0, 18'h0, 0, 1);
    check("er_htrans_1", htrans, 2'b00);
    check("er_rsp_1", rsp_data_vld, 0);
    step(0, 18'h0, 1, 1);
    check("er_htrans_2", htrans, 2'b10);
    check("er_haddr_2", haddr, exp_haddr(18'h00301));
    check("er_rsp_2", rsp_data_vld, 1);
    check("er_err", rsp_err, 1);
    check("er_data", rsp_data, 16'h0);
    step(0, 18'h0, 1, 0);
    check("er_rsp_b", rsp_data_vld, 1);
    check("er_err_b", rsp_err, 0);
    check("er_sticky", err_sticky, 1);
    step(0, 18'h0, 1, 0);
    check("er_sticky_hold", err_sticky, 1);
    err_clr = 1'b1;
    step(0, 18'h0, 1, 0);
    err_clr = 1'b0;
    step(0, 18'h0, 1, 0);
    check("er_sticky_clr", err_sticky, 0);

    // Reset with two transfers outstanding
    step(1, 18'h00400, 1, 0);
    step(1, 18'h00401, 1, 0);
    @(posedge clk);
    #1;
    req_addr_vld = 1'b0;
    hready = 1'b0;
    #1;
    check("rm_rdy_pre", req_addr_rdy, 0);
    rst = 1'b1;
    #1;
    check("rm_rdy", req_addr_rdy, 1);
    check("rm_htrans", htrans, 2'b00);
    hready = 1'b1;
    #1;
    check("rm_rsp", rsp_data_vld, 0);
    check("rm_sticky", err_sticky, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(0, 18'h0, 1, 0);
      check("rm_no_rsp", rsp_data_vld, 0);
      check("rm_idle", htrans, 2'b00);
    end

    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
